// File: rtl/lfsr_pkg.sv
// Shared widths, polynomial and lock-up substitute for the 16-bit LFSR.
package lfsr_pkg;

  localparam int LFSR_W = 16;

  typedef logic [LFSR_W-1:0] lfsr_t;

  // x^16 + x^15 + x^13 + x^4 + 1 : taps on state bits 15, 14, 12 and 3.
  localparam lfsr_t LFSR_TAPS     = 16'hD008;

  // Loaded instead of an all-zero seed, which would lock the register at zero.
  localparam lfsr_t LFSR_ZERO_SUB = 16'hACE1;

endpackage : lfsr_pkg

// File: rtl/lfsr_next.sv
// Combinational next-state function of a Fibonacci LFSR.
// The feedback is the XOR of the tapped bits, and it enters at bit 0 as the state shifts left.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = LFSR_W,
  parameter logic [WIDTH-1:0] TAP_MASK = LFSR_TAPS
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] w_tapped;
  logic             w_fb;

  assign w_tapped = i_state & TAP_MASK;
  assign w_fb     = ^w_tapped;

  // Shift left by one and feed the parity of the tapped bits into the LSB.
  always_comb begin
    o_next = {i_state[WIDTH-2:0], w_fb};
  end

endmodule : lfsr_next

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR with a seed reload on synchronous active-low reset.
// The state register drives out directly, so out has no combinational path from any input.
module lfsr16
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = LFSR_W,
  parameter logic [WIDTH-1:0] TAP_MASK = LFSR_TAPS,
  parameter logic [WIDTH-1:0] ZERO_SUB = LFSR_ZERO_SUB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load;

  // A zero seed would freeze the generator, so replace it with a known non-zero value.
  assign w_load = (seed == '0) ? ZERO_SUB : seed;

  lfsr_next #(
    .WIDTH    (WIDTH),
    .TAP_MASK (TAP_MASK)
  ) u_next (
    .i_state (r_state),
    .o_next  (w_next)
  );

  // Reload the seed every cycle while reset is low; otherwise advance one step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= w_load;
    end else begin
      r_state <= w_next;
    end
  end

  assign out = r_state;

endmodule : lfsr16

// File: tb/tb_lfsr16.sv
// Directed bench for lfsr16. Expected values are either hand-computed constants or come from
// a bit-level reference step that is written independently of the RTL.
module tb_lfsr16;

  logic        clk;
  logic        rst;
  logic [15:0] seed;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;

  lfsr16 dut (
    .clk  (clk),
    .rst  (rst),
    .seed (seed),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference step: taps on bits 15, 14, 12 and 3, with the state shifting toward the MSB.
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

  // Wait for the next rising edge, then sample 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    $display("check %-12s out=%h exp=%h", tag, obs, exp);
  endtask

  initial begin
    logic [15:0] model;
    int          first_ret;
    int          zero_seen;

    rst  = 1'b0;
    seed = 16'h8DCC;

    // Test 1: basic sequence from seed 8DCC.
    step();
    chk("t1_reset", out, 16'h8DCC);
    rst = 1'b1;
    step(); chk("t1_s1", out, 16'h1B98);
    step(); chk("t1_s2", out, 16'h3730);
    step(); chk("t1_s3", out, 16'h6E61);

    // Test 2: a zero seed is replaced by ACE1.
    rst  = 1'b0;
    seed = 16'h0000;
    step(); chk("t2_zero_sub", out, 16'hACE1);
    rst = 1'b1;
    step(); chk("t2_s1", out, 16'h59C3);

    // Test 3: while reset is held, out tracks seed and does not advance.
    rst  = 1'b0;
    seed = 16'h1111;
    step(); chk("t3_hold1", out, 16'h1111);
    seed = 16'h2222;
    step(); chk("t3_hold2", out, 16'h2222);
    seed = 16'h3333;
    step(); chk("t3_hold3", out, 16'h3333);

    // Test 4: reset in the middle of a run.
    seed = 16'h8DCC;
    step();
    rst   = 1'b1;
    model = 16'h8DCC;
    for (int i = 0; i < 10; i++) begin
      step();
      model = ref_step(model);
    end
    chk("t4_run10", out, model);
    rst = 1'b0;
    step(); chk("t4_reload", out, 16'h8DCC);
    rst = 1'b1;
    step(); chk("t4_s1", out, 16'h1B98);
    step(); chk("t4_s2", out, 16'h3730);
    step(); chk("t4_s3", out, 16'h6E61);

    // Test 6: changing seed while running has no effect.
    rst  = 1'b0;
    seed = 16'h1234;
    step(); chk("t6_reset", out, 16'h1234);
    rst   = 1'b1;
    model = 16'h1234;
    for (int i = 0; i < 20; i++) begin
      seed = 16'($urandom);
      step();
      model = ref_step(model);
      chk($sformatf("t6_cyc%0d", i), out, model);
    end

    // Test 5: full period from seed 0001. State must return to 0001 only at step 65535,
    // and must never be zero on the way.
    rst  = 1'b0;
    seed = 16'h0001;
    step(); chk("t5_reset", out, 16'h0001);
    rst       = 1'b1;
    first_ret = 0;
    zero_seen = 0;
    for (int i = 1; i <= 65535; i++) begin
      step();
      if (out === 16'h0000) zero_seen++;
      if (out === 16'h0001 && first_ret == 0) first_ret = i;
    end
    chk("t5_period", 16'(first_ret), 16'hFFFF);
    chk("t5_nozero", 16'(zero_seen), 16'h0000);
    step(); chk("t5_wrap_s1", out, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_lfsr16
